// File: rtl/dpram_param_be_pkg.sv
// -----------------------------------------------------------------------------
// dpram_param_be_pkg
// Shared definitions for the parametrised byte-enable dual-port RAM:
//   - read-during-write mode constants for the opposite port
//   - encodings of the post-reset clear sequencer states
//   - lane-count derivation used to size the byte-enable ports
// -----------------------------------------------------------------------------
package dpram_param_be_pkg;

   // Cross-port same-address read during write: old word or merged new word.
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic [1:0] {
      ST_RST   = 2'b00,
      ST_CLEAR = 2'b01,
      ST_READY = 2'b10
   } clr_state_e;

   function automatic int num_lanes(input int dwidth, input int lane_w);
      return dwidth / lane_w;
   endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// -----------------------------------------------------------------------------
// dpram_port_pipe
// Read-return pipeline for one RAM port. Captures the read word when a read
// is accepted, optionally adds a second register stage, produces a one-cycle
// valid strobe per read and holds the last returned word otherwise.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears data and valid)
//   rd_i     a read was accepted this cycle
//   rdata_i  word read from the array (already RDW-resolved)
//   out_o    returned read data, held between reads
//   valid_o  single-cycle strobe, out_o carries new data
// -----------------------------------------------------------------------------
module dpram_port_pipe
   import dpram_param_be_pkg::*;
#(
   parameter int DWIDTH  = 60,
   parameter int OUT_REG = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rd_i,
   input  logic [DWIDTH-1:0] rdata_i,
   output logic [DWIDTH-1:0] out_o,
   output logic              valid_o
);

   logic              vld_p0_q;
   logic [DWIDTH-1:0] data_p0_q;

   // Stage p0: array read capture; data only loads on a read so it holds.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p0_q  <= 1'b0;
         data_p0_q <= '0;
      end else begin
         vld_p0_q <= rd_i;
         if (rd_i) begin
            data_p0_q <= rdata_i;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              vld_p1_q;
         logic [DWIDTH-1:0] data_p1_q;

         // Stage p1: optional output register.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               vld_p1_q  <= 1'b0;
               data_p1_q <= '0;
            end else begin
               vld_p1_q <= vld_p0_q;
               if (vld_p0_q) begin
                  data_p1_q <= data_p0_q;
               end
            end
         end

         assign out_o   = data_p1_q;
         assign valid_o = vld_p1_q;
      end else begin : g_no_out_reg
         assign out_o   = data_p0_q;
         assign valid_o = vld_p0_q;
      end
   endgenerate

endmodule

// File: rtl/dpram_param_be.sv
// -----------------------------------------------------------------------------
// dpram_param_be
// Parametrised true dual-port RAM with per-lane byte enables, per-port access
// enables, selectable cross-port read-during-write result, optional output
// register, read-valid strobes, write-write collision arbitration (port A wins
// on overlapping lanes) and a post-reset clear sequencer.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   en_x, wren_x                 access enable; write when wren_x, else read
//   be_x                         lane write enables (NUM_LANES bits)
//   address_x, data_x            address and write data
//   out_x, valid_x               read data and its one-cycle valid strobe
//   init_done                    ports accept requests (clear finished)
//   collision                    pulse: same-address writes with overlapping be
// -----------------------------------------------------------------------------
module dpram_param_be
   import dpram_param_be_pkg::*;
#(
   parameter int AWIDTH         = 10,
   parameter int NUM_WORDS      = 1024,
   parameter int DWIDTH         = 60,
   parameter int LANE_W         = 20,
   parameter int OUT_REG        = 0,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int NUM_LANES     = num_lanes(DWIDTH, LANE_W)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_a,
   input  logic                 wren_a,
   input  logic [NUM_LANES-1:0] be_a,
   input  logic [AWIDTH-1:0]    address_a,
   input  logic [DWIDTH-1:0]    data_a,
   output logic [DWIDTH-1:0]    out_a,
   output logic                 valid_a,
   input  logic                 en_b,
   input  logic                 wren_b,
   input  logic [NUM_LANES-1:0] be_b,
   input  logic [AWIDTH-1:0]    address_b,
   input  logic [DWIDTH-1:0]    data_b,
   output logic [DWIDTH-1:0]    out_b,
   output logic                 valid_b,
   output logic                 init_done,
   output logic                 collision
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0]  CLR_LAST  = IDX_W'(NUM_WORDS - 1);
   localparam logic [AWIDTH:0]   WORDS_EXT = (AWIDTH + 1)'(NUM_WORDS);

   logic [DWIDTH-1:0] mem_q [NUM_WORDS];

   clr_state_e        state_q, state_d;
   logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;
   logic              collision_q, collision_d;

   logic              ready, clearing;
   logic              in_rng_a, in_rng_b;
   logic [IDX_W-1:0]  idx_a, idx_b;
   logic              wr_a, wr_b, rd_a, rd_b;
   logic              same_addr;
   logic [DWIDTH-1:0] rdata_a, rdata_b;

   // Clear sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RST;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_RST: begin
            clr_addr_d = '0;
            state_d    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == CLR_LAST) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d = ST_RST;
         end
      endcase
   end

   // Reset is folded in so no user access slips through on the reset edge.
   assign ready     = (state_q == ST_READY) && !reset;
   assign clearing  = (state_q == ST_CLEAR);
   assign init_done = (state_q == ST_READY);

   // Out-of-range addresses must not alias onto real words through idx_x.
   assign in_rng_a  = ({1'b0, address_a} < WORDS_EXT);
   assign in_rng_b  = ({1'b0, address_b} < WORDS_EXT);
   assign idx_a     = address_a[IDX_W-1:0];
   assign idx_b     = address_b[IDX_W-1:0];
   assign same_addr = (address_a == address_b);

   assign wr_a = ready && en_a && wren_a && in_rng_a;
   assign wr_b = ready && en_b && wren_b && in_rng_b;
   assign rd_a = ready && en_a && !wren_a;
   assign rd_b = ready && en_b && !wren_b;

   // Array write: B lanes first, then A, so A owns any overlapping lane.
   always_ff @(posedge clk) begin
      if (clearing) begin
         mem_q[clr_addr_q] <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_b && be_b[l]) begin
               mem_q[idx_b][l*LANE_W +: LANE_W] <= data_b[l*LANE_W +: LANE_W];
            end
            if (wr_a && be_a[l]) begin
               mem_q[idx_a][l*LANE_W +: LANE_W] <= data_a[l*LANE_W +: LANE_W];
            end
         end
      end
   end

   // Read word per port; in new-data mode the opposite port's write lanes
   // are forwarded over the stored word.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (in_rng_a) begin
         rdata_a = mem_q[idx_a];
      end
      if (in_rng_b) begin
         rdata_b = mem_q[idx_b];
      end
      if (RDW_MODE != RDW_OLD) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_b && same_addr && be_b[l]) begin
               rdata_a[l*LANE_W +: LANE_W] = data_b[l*LANE_W +: LANE_W];
            end
            if (wr_a && same_addr && be_a[l]) begin
               rdata_b[l*LANE_W +: LANE_W] = data_a[l*LANE_W +: LANE_W];
            end
         end
      end
   end

   assign collision_d = wr_a && wr_b && same_addr && (|(be_a & be_b));

   always_ff @(posedge clk) begin
      if (reset) begin
         collision_q <= 1'b0;
      end else begin
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

   dpram_port_pipe #(
      .DWIDTH  (DWIDTH),
      .OUT_REG (OUT_REG)
   ) u_pipe_a (
      .clk_i   (clk),
      .rst_i   (reset),
      .rd_i    (rd_a),
      .rdata_i (rdata_a),
      .out_o   (out_a),
      .valid_o (valid_a)
   );

   dpram_port_pipe #(
      .DWIDTH  (DWIDTH),
      .OUT_REG (OUT_REG)
   ) u_pipe_b (
      .clk_i   (clk),
      .rst_i   (reset),
      .rd_i    (rd_b),
      .rdata_i (rdata_b),
      .out_o   (out_b),
      .valid_o (valid_b)
   );

endmodule

// File: tb/tb_dpram_param_be.sv
// -----------------------------------------------------------------------------
// tb_dpram_param_be
// Two RAM instances (16 words) share one stimulus stream:
//   dut0: read latency 1, old data on cross-port read-during-write
//   dut1: read latency 2, merged new data on cross-port read-during-write
// Expected read returns and collision pulses are queued with their due cycle
// when a request is driven and checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_dpram_param_be;

   localparam int AW = 5;
   localparam int NW = 16;
   localparam int DW = 60;

   logic          clk;
   logic          reset;
   logic          en_a, wren_a, en_b, wren_b;
   logic [2:0]    be_a, be_b;
   logic [AW-1:0] address_a, address_b;
   logic [DW-1:0] data_a, data_b;

   logic [DW-1:0] out_a0, out_b0, out_a1, out_b1;
   logic          valid_a0, valid_b0, valid_a1, valid_b1;
   logic          init_done0, init_done1, collision0, collision1;

   dpram_param_be #(
      .AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .LANE_W(20),
      .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) dut0 (
      .clk(clk), .reset(reset),
      .en_a(en_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
      .data_a(data_a), .out_a(out_a0), .valid_a(valid_a0),
      .en_b(en_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
      .data_b(data_b), .out_b(out_b0), .valid_b(valid_b0),
      .init_done(init_done0), .collision(collision0)
   );

   dpram_param_be #(
      .AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .LANE_W(20),
      .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) dut1 (
      .clk(clk), .reset(reset),
      .en_a(en_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
      .data_a(data_a), .out_a(out_a1), .valid_a(valid_a1),
      .en_b(en_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
      .data_b(data_b), .out_b(out_b1), .valid_b(valid_b1),
      .init_done(init_done1), .collision(collision1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ids: 0 dut0 A, 1 dut0 B, 2 dut1 A, 3 dut1 B, 4 dut0 coll, 5 dut1 coll
   typedef struct {
      int            id;
      int            due;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mem_m [NW];
   logic [DW-1:0] last [4];
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   logic          rdy_m = 1'b0;
   logic          init_exp = 1'b0;
   logic          mon_en = 1'b0;
   logic          pend_rst = 1'b1;
   logic          fin_req = 1'b0;
   logic          fin_ack = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] w,
                                           input logic [DW-1:0] d,
                                           input logic [2:0] be);
      logic [DW-1:0] r;
      r = w;
      for (int l = 0; l < 3; l++) begin
         if (be[l]) r[l*20 +: 20] = d[l*20 +: 20];
      end
      return r;
   endfunction

   function automatic string name_of(input int id);
      case (id)
         0: return "dut0_port_a";
         1: return "dut0_port_b";
         2: return "dut1_port_a";
         3: return "dut1_port_b";
         4: return "dut0_collision";
         default: return "dut1_collision";
      endcase
   endfunction

   // Monitor: compare every output against the scoreboard on the falling edge.
   always @(negedge clk) begin
      int            idx;
      logic          ev, ov;
      logic [DW-1:0] ed, od;
      if (mon_en) begin
         if (pend_rst) begin
            for (int i = 0; i < 4; i++) last[i] = '0;
         end
         n_tests++;
         assert (init_done0 === init_exp && init_done1 === init_exp) else begin
            n_fail++;
            $error("FAIL init_done: got %0b/%0b, want %0b", init_done0, init_done1, init_exp);
         end
         for (int id = 0; id < 6; id++) begin
            idx = -1;
            for (int k = 0; k < sb.size(); k++) begin
               if (idx < 0 && sb[k].id == id) idx = k;
            end
            ev = 1'b0;
            ed = (id < 4) ? last[id] : '0;
            if (idx >= 0 && sb[idx].due == cyc) begin
               ev = 1'b1;
               if (id < 4) ed = sb[idx].d;
               sb.delete(idx);
            end
            case (id)
               0: begin ov = valid_a0; od = out_a0; end
               1: begin ov = valid_b0; od = out_b0; end
               2: begin ov = valid_a1; od = out_a1; end
               3: begin ov = valid_b1; od = out_b1; end
               4: begin ov = collision0; od = '0; end
               default: begin ov = collision1; od = '0; end
            endcase
            if (id < 4) begin
               n_tests++;
               assert (ov === ev && od === ed) else begin
                  n_fail++;
                  $error("FAIL %s: got valid=%0b data=%h, want valid=%0b data=%h",
                         name_of(id), ov, od, ev, ed);
               end
               if (ev) last[id] = ed;
            end else if (ev || ov !== 1'b0) begin
               n_tests++;
               assert (ov === ev) else begin
                  n_fail++;
                  $error("FAIL %s: got %0b, want %0b", name_of(id), ov, ev);
               end
            end
         end
         pend_rst = reset;
         if (fin_req && !fin_ack) begin
            n_tests++;
            assert (sb.size() == 0) else begin
               n_fail++;
               $error("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
            end
            fin_ack = 1'b1;
         end
      end
   end

   // One request cycle on both ports; expectations are queued before the
   // model memory is updated so same-cycle reads see the pre-write word.
   task automatic op(input logic ea, input logic wa, input logic [2:0] bea,
                     input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic eb, input logic wb, input logic [2:0] beb,
                     input logic [AW-1:0] ab, input logic [DW-1:0] db);
      logic          wra, wrb;
      logic [DW-1:0] old_w, new_w;
      en_a = ea; wren_a = wa; be_a = bea; address_a = aa; data_a = da;
      en_b = eb; wren_b = wb; be_b = beb; address_b = ab; data_b = db;
      if (rdy_m) begin
         wra = ea && wa && (aa < NW);
         wrb = eb && wb && (ab < NW);
         if (ea && !wa) begin
            old_w = (aa < NW) ? mem_m[aa[3:0]] : '0;
            new_w = (wrb && ab == aa) ? merge(old_w, db, beb) : old_w;
            sb.push_back('{id: 0, due: cyc + 1, d: old_w});
            sb.push_back('{id: 2, due: cyc + 2, d: new_w});
         end
         if (eb && !wb) begin
            old_w = (ab < NW) ? mem_m[ab[3:0]] : '0;
            new_w = (wra && ab == aa) ? merge(old_w, da, bea) : old_w;
            sb.push_back('{id: 1, due: cyc + 1, d: old_w});
            sb.push_back('{id: 3, due: cyc + 2, d: new_w});
         end
         if (wra && wrb && aa == ab && (bea & beb) != 3'b000) begin
            sb.push_back('{id: 4, due: cyc + 1, d: '0});
            sb.push_back('{id: 5, due: cyc + 1, d: '0});
         end
         if (wrb) mem_m[ab[3:0]] = merge(mem_m[ab[3:0]], db, beb);
         if (wra) mem_m[aa[3:0]] = merge(mem_m[aa[3:0]], da, bea);
      end
      @(posedge clk);
      #1;
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 3'b000, '0, '0);
   endtask

   task automatic rd_a(input logic [AW-1:0] a);
      op(1'b1, 1'b0, 3'b000, a, '0, 1'b0, 1'b0, 3'b000, '0, '0);
   endtask

   task automatic rd_b(input logic [AW-1:0] a);
      op(1'b0, 1'b0, 3'b000, '0, '0, 1'b1, 1'b0, 3'b000, a, '0);
   endtask

   task automatic wr_a(input logic [2:0] be, input logic [AW-1:0] a, input logic [DW-1:0] d);
      op(1'b1, 1'b1, be, a, d, 1'b0, 1'b0, 3'b000, '0, '0);
   endtask

   // Release reset and walk through the clear while issuing reads that must
   // be ignored; init_done is expected exactly NW+1 edges after release.
   task automatic release_and_clear();
      reset = 1'b0;
      for (int i = 1; i <= NW + 1; i++) begin
         op(1'b1, 1'b0, 3'b000, AW'(i % NW), '0, 1'b1, 1'b0, 3'b000, AW'((i + 3) % NW), '0);
         if (i == NW + 1) begin
            init_exp = 1'b1;
            rdy_m    = 1'b1;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      en_a = 1'b0; wren_a = 1'b0; be_a = '0; address_a = '0; data_a = '0;
      en_b = 1'b0; wren_b = 1'b0; be_b = '0; address_b = '0; data_b = '0;
      for (int i = 0; i < NW; i++) mem_m[i] = '0;
      for (int i = 0; i < 4; i++) last[i] = '0;

      repeat (3) idle();
      mon_en = 1'b1;

      // Clear sequence, then every word reads zero on both ports.
      release_and_clear();
      for (int i = 0; i < NW; i++) begin
         op(1'b1, 1'b0, 3'b000, AW'(i), '0, 1'b1, 1'b0, 3'b000, AW'(NW - 1 - i), '0);
      end

      // Byte-enable merge: expected 0xFFFFF00000FFFFF on B.
      wr_a(3'b111, 5'd5, 60'hFFF_FFFF_FFFF_FFFF);
      wr_a(3'b010, 5'd5, 60'h000_0000_0000_0000);
      rd_b(5'd5);
      idle();

      // Latency and single-cycle valid.
      wr_a(3'b111, 5'd3, 60'h123);
      rd_a(5'd3);
      repeat (3) idle();

      // Cross-port read during write on address 7.
      wr_a(3'b111, 5'd7, 60'hAAA);
      op(1'b1, 1'b1, 3'b111, 5'd7, 60'hBBB, 1'b1, 1'b0, 3'b000, 5'd7, '0);
      rd_b(5'd7);
      op(1'b1, 1'b1, 3'b100, 5'd7, 60'hFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b000, 5'd7, '0);
      rd_b(5'd7);

      // Write-write collision on address 9, overlapping then disjoint lanes.
      op(1'b1, 1'b1, 3'b111, 5'd9, 60'h111, 1'b1, 1'b1, 3'b110, 5'd9, 60'h222);
      rd_a(5'd9);
      op(1'b1, 1'b1, 3'b001, 5'd9, 60'h333, 1'b1, 1'b1, 3'b110, 5'd9, 60'h44444_55555_66666);
      op(1'b1, 1'b0, 3'b000, 5'd9, '0, 1'b1, 1'b0, 3'b000, 5'd9, '0);
      idle();

      // Out-of-range write dropped (no alias onto 4), out-of-range read is 0.
      wr_a(3'b111, 5'd20, 60'hDEAD_BEEF);
      rd_a(5'd20);
      rd_b(5'd4);
      // Legal no-op write, then back-to-back reads.
      wr_a(3'b000, 5'd3, 60'hFFF_FFFF_FFFF_FFFF);
      rd_a(5'd3);
      rd_a(5'd5);
      rd_a(5'd9);
      repeat (3) idle();

      // Reset mid-clear at clr_addr 8; address 12 must be cleared again.
      wr_a(3'b111, 5'd12, 60'hC0FFEE);
      wr_a(3'b111, 5'd2, 60'h5A5A5);
      rd_b(5'd12);
      repeat (2) idle();
      reset = 1'b1;
      rdy_m = 1'b0;
      for (int i = 0; i < NW; i++) mem_m[i] = '0;
      idle();
      init_exp = 1'b0;
      reset = 1'b0;
      repeat (NW / 2 + 1) idle();
      reset = 1'b1;
      idle();
      release_and_clear();
      for (int i = 0; i < NW; i++) begin
         op(1'b1, 1'b0, 3'b000, AW'(i), '0, 1'b1, 1'b0, 3'b000, AW'(i), '0);
      end
      repeat (4) idle();

      fin_req = 1'b1;
      for (int k = 0; k < 10 && !fin_ack; k++) @(negedge clk);
      #1;
      if (!fin_ack) begin
         $display("FAIL final_check: monitor did not respond");
         $fatal(1, "monitor stalled");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dpram_param_be.md
Name: dpram_param_be

Overview:
- Parametrised true dual-port RAM; the next generation of the team's fixed 1024x60 dual-port RAM.
- Adds:
  - configurable depth and width
  - per-lane byte enables
  - per-port access enable
  - selectable read-during-write result on the opposite port
  - optional output register stage
  - read-valid strobes
  - write-write collision arbitration and flag
  - post-reset memory-clear sequencer
- Instantiated inside accelerator tiles as weight/activation buffer storage.

Parameters:
- AWIDTH, 10, address width.
- NUM_WORDS, 1024, depth; must be <= 2**AWIDTH.
- DWIDTH, 60, data width.
- LANE_W, 20, byte-enable lane width; DWIDTH must be a multiple of LANE_W; NUM_LANES = DWIDTH/LANE_W.
- OUT_REG, 0, 0 = read latency 1; 1 = read latency 2.
- RDW_MODE, 0, cross-port same-address read during write: 0 returns old data, 1 returns new (merged) data.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = no clear.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- en_a  in  1  port A access enable.
- wren_a  in  1  port A write (when en_a); read when en_a && !wren_a.
- be_a  in  NUM_LANES  port A lane write enables.
- address_a  in  AWIDTH  port A address.
- data_a  in  DWIDTH  port A write data.
- out_a  out  DWIDTH  port A read data.
- valid_a  out  1  out_a holds new read data this cycle.
- en_b, wren_b, be_b, address_b, data_b, out_b, valid_b: same as port A, for port B.
- init_done  out  1  high when ports accept requests.
- collision  out  1  one-cycle pulse on a write-write same-address conflict.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - out_a/out_b = 0, valid_a/valid_b = 0, collision = 0, init_done = 0.
  - Memory contents are not reset, except by the clear sequence.
  - Pipeline registers cleared.
- Clear FSM states: RST -> CLEAR -> READY.
  - RST is held while reset = 1.
  - First cycle after reset deasserts:
    - CLEAR_ON_RESET = 1: enter CLEAR with clr_addr = 0.
    - CLEAR_ON_RESET = 0: go directly to READY.
  - CLEAR: write all-zero, all lanes, to clr_addr each cycle; clr_addr increments.
    - After the write of NUM_WORDS-1, go to READY.
    - init_done rises the cycle READY is entered: NUM_WORDS+1 cycles after reset falls.
  - While not READY:
    - en_a/en_b are ignored.
    - No user writes, no valid pulses, collision stays 0.
  - Reset asserted mid-CLEAR: return to RST; clear restarts from 0 afterwards.
- Write:
  - Occurs when en && wren && READY.
  - Only lanes with be[i] = 1 are updated; other lanes keep their prior value.
  - be = 0 with wren = 1 is a legal no-op write.
  - A write produces no read on that port: out holds its value and valid stays 0.
- Read:
  - Occurs when en && !wren && READY.
  - OUT_REG = 0: out and valid are updated at edge N+1 for a request at edge N.
  - OUT_REG = 1: out and valid are updated one edge later.
  - valid is a single-cycle pulse per read.
  - out holds its last value when no read completes.
- Cross-port read during write (one port writes address X, the other reads X in the same cycle):
  - RDW_MODE = 0: reader gets the pre-write word.
  - RDW_MODE = 1: reader gets the post-write word, with lanes merged per be.
- Write-write to the same address in the same cycle:
  - Lanes enabled on A take A data.
  - Lanes enabled only on B take B data.
  - collision pulses 1 the next cycle, only if the be sets overlap.
- Read-read to the same address: both ports return the same word; no conflict.
- Addresses >= NUM_WORDS:
  - Writes are dropped.
  - Reads return 0 with valid still pulsed.

Decomposition:
- Shared package/header:
  - RDW_OLD = 0 and RDW_NEW = 1 constants.
  - Clear-FSM state encodings ST_RST, ST_CLEAR, ST_READY (2-bit).
  - NUM_LANES derivation function.
- One natural sub-module: dpram_port_pipe.
  - Per-port read pipeline: optional OUT_REG stage, valid strobe, hold-last-value register.
  - Instantiated twice.
- Storage array, lane-merge and arbitration remain in the top module.

Test Plan:
- Clear sequence (CLEAR_ON_RESET = 1, NUM_WORDS = 16):
  - Release reset, then read all 16 addresses.
  - init_done rises 17 cycles after reset falls; every read returns 0.
  - Requests issued before init_done produce no valid.
- Byte-enable merge (DWIDTH = 60, LANE_W = 20):
  - A writes 0xFFFFFFFFFFFFFFF be=111 to addr 5, then 0x000000000000000 be=010.
  - B reads addr 5: out_b = 0xFFFFF00000FFFFF.
- Latency:
  - A reads addr 3 holding 0x123 with OUT_REG = 0: valid_a and out_a = 0x123 at edge +1.
  - Same with OUT_REG = 1: result at edge +2.
  - valid_a is high for exactly 1 cycle in both cases.
- Cross-port RDW:
  - Addr 7 holds 0xAAA; A writes 0xBBB (be=111) while B reads 7.
  - RDW_MODE = 0: out_b = 0xAAA. RDW_MODE = 1: out_b = 0xBBB.
  - A subsequent read returns 0xBBB.
- Write collision on addr 9:
  - A writes 0x111 be=111 and B writes 0x222 be=110 in the same cycle.
  - Read-back gives the A word in all lanes; collision pulses once.
  - With A be=001, B be=110: lane 0 comes from A, lanes 1-2 from B; collision stays 0.
- Reset mid-clear:
  - Assert reset for 1 cycle at clr_addr = 8.
  - init_done falls and stays 0 for NUM_WORDS+1 cycles after reset falls; all words read 0.
